cs_window_filter: RTL

//  Parametrised successor of the CS smoothing filter: sliding window of WIN samples, finds Xappr
//  (largest window sample <= window average), emits Y = (sum + WIN*Xappr) >> SHIFT.

---
 rtl/cs_window_filter_pkg.sv | 20 ++
 rtl/cs_window_filter_if.sv | 25 ++
 rtl/cs_window_filter_approx_select.sv | 26 ++
 rtl/cs_window_filter.sv | 115 +++++++++++
 4 files changed

// File: rtl/cs_window_filter_pkg.sv
// cs_window_filter shared package
// Width helpers and mode encodings
package cs_pkg;

  localparam logic CS_MODE_APPR = 1'b0;
  localparam logic CS_MODE_AVG  = 1'b1;

  function automatic int sum_w(int dw, int win);
    return dw + $clog2(win);
  endfunction

  function automatic int int_w(int dw, int win);
    return dw + $clog2(2 * win);
  endfunction

  function automatic int out_w(int dw, int win, int shift);
    return int_w(dw, win) - shift;
  endfunction

endpackage

// File: rtl/cs_window_filter_if.sv
// cs_window_filter sample/result interface
// Source drives samples, filter returns results
interface cs_window_filter_if #(
  parameter int DW = 8,
  parameter int OW = 10
);

  logic          in_valid;
  logic [DW-1:0] X;
  logic          mode;
  logic          flush;
  logic          out_valid;
  logic [OW-1:0] Y;

  modport master (
    output in_valid, X, mode, flush,
    input  out_valid, Y
  );

  modport slave (
    input  in_valid, X, mode, flush,
    output out_valid, Y
  );

endinterface

// File: rtl/cs_window_filter_approx_select.sv
// cs_approx_select: largest window entry
// not exceeding the window average
module cs_approx_select
  import cs_pkg::*;
#(
  parameter int DW  = 8,
  parameter int WIN = 9,
  parameter int SW  = 12
) (
  input  logic [WIN-1:0][DW-1:0] win,
  input  logic [SW-1:0]          sum,
  output logic [DW-1:0]          xappr
);

  // x <= sum/WIN tested as x*WIN <= sum
  always_comb begin
    xappr = '0;
    for (int i = 0; i < WIN; i++) begin
      if ((SW'(win[i]) * SW'(WIN) <= sum) &&
          (win[i] > xappr)) begin
        xappr = win[i];
      end
    end
  end

endmodule

// File: rtl/cs_window_filter.sv
// cs_window_filter: sliding-window CS smoother
// with flush and plain-average mode
module cs_window_filter
  import cs_pkg::*;
#(
  parameter int DW    = 8,
  parameter int WIN   = 9,
  parameter int SHIFT = 3
) (
  input  logic              clk,
  input  logic              reset,
  cs_window_filter_if.slave bus
);

  localparam int SW = sum_w(DW, WIN);
  localparam int IW = int_w(DW, WIN);
  localparam int OW = out_w(DW, WIN, SHIFT);
  localparam int PW = $clog2(WIN);
  localparam int FW = $clog2(WIN + 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(WIN - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(WIN);
  localparam logic [FW-1:0] FILL_LAST = FW'(WIN - 1);

  logic [WIN-1:0][DW-1:0] win_q;
  logic [PW-1:0]          ptr_q;
  logic [FW-1:0]          fill_q;
  logic [SW-1:0]          sum_q;
  logic                   v1_q;
  logic                   m1_q;
  logic                   v2_q;
  logic [SW-1:0]          sum2_q;
  logic [DW-1:0]          xap2_q;
  logic                   ov_q;
  logic [OW-1:0]          y_q;

  logic          full;
  logic [DW-1:0] oldest;
  logic [SW-1:0] sum_nx;
  logic [PW-1:0] ptr_nx;
  logic [DW-1:0] x_cs;
  logic [DW-1:0] x_avg;
  logic [DW-1:0] x_sel;
  logic [IW-1:0] y_full;

  assign full   = (fill_q == FILL_FULL);
  assign oldest = full ? win_q[ptr_q] : '0;
  assign sum_nx = sum_q + SW'(bus.X) - SW'(oldest);
  assign ptr_nx = (ptr_q == PTR_LAST) ? '0
                                      : ptr_q + PW'(1);

  cs_approx_select #(
    .DW  (DW),
    .WIN (WIN),
    .SW  (SW)
  ) u_sel (
    .win   (win_q),
    .sum   (sum_q),
    .xappr (x_cs)
  );

  assign x_avg  = DW'(sum_q / SW'(WIN));
  assign x_sel  = (m1_q == CS_MODE_AVG) ? x_avg : x_cs;
  assign y_full = IW'(sum2_q) + IW'(WIN) * IW'(xap2_q);

  // S1: window, pointer, fill and running sum
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q  <= '0;
      ptr_q  <= '0;
      fill_q <= '0;
      sum_q  <= '0;
      v1_q   <= 1'b0;
      m1_q   <= CS_MODE_APPR;
    end else if (bus.flush) begin
      ptr_q  <= bus.in_valid ? PW'(1) : '0;
      fill_q <= bus.in_valid ? FW'(1) : '0;
      sum_q  <= bus.in_valid ? SW'(bus.X) : '0;
      if (bus.in_valid) win_q[0] <= bus.X;
      v1_q   <= 1'b0;
      m1_q   <= bus.mode;
    end else begin
      v1_q <= bus.in_valid && (fill_q >= FILL_LAST);
      if (bus.in_valid) begin
        win_q[ptr_q] <= bus.X;
        ptr_q        <= ptr_nx;
        sum_q        <= sum_nx;
        m1_q         <= bus.mode;
        if (!full) fill_q <= fill_q + FW'(1);
      end
    end
  end

  // S2 selection and output; flush kills in-flight results
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2_q   <= 1'b0;
      sum2_q <= '0;
      xap2_q <= '0;
      ov_q   <= 1'b0;
      y_q    <= '0;
    end else begin
      v2_q <= v1_q && !bus.flush;
      if (v1_q) begin
        sum2_q <= sum_q;
        xap2_q <= x_sel;
      end
      ov_q <= v2_q && !bus.flush;
      if (v2_q && !bus.flush) y_q <= y_full[IW-1:SHIFT];
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.Y         = y_q;

endmodule
